// File: rtl/scan_chain_scheduler.sv
// rtl/scan_chain_scheduler.sv - round-robin shared scan-chain sequencer (reset phase, then serial shift/capture)
module scan_chain_scheduler #(
    parameter int CHAIN_LEN    = 8,
    parameter int CLK_DIV      = 128,
    parameter int RESET_CYCLES = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req,
    input  logic [CHAIN_LEN-1:0] pattern0,
    input  logic [CHAIN_LEN-1:0] pattern1,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] rdata,
    output logic                 scan_clk,
    output logic                 scan_din,
    output logic                 scan_reset,
    input  logic                 scan_dout
);

    localparam int DW   = $clog2(CLK_DIV);
    localparam int MAXP = (RESET_CYCLES > CHAIN_LEN) ? RESET_CYCLES : CHAIN_LEN;
    localparam int PW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [PW-1:0] RST_LAST = PW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] SH_LAST  = PW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RESET, ST_SHIFT, ST_DONE} state_t;

    state_t               state, state_n;
    logic [DW-1:0]        div_cnt, div_n;
    logic [PW-1:0]        per_cnt, per_n;
    logic [1:0]           grant_n;
    logic                 rr, rr_n;
    logic [CHAIN_LEN-1:0] sreg, sreg_n;
    logic [CHAIN_LEN-1:0] rdata_n;
    logic [CHAIN_LEN:0]   cap;
    logic                 clk_n, din_n, win, last_per;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            div_cnt  <= '0;
            per_cnt  <= '0;
            grant    <= 2'b00;
            rr       <= 1'b0;
            sreg     <= '0;
            rdata    <= '0;
            scan_clk <= 1'b0;
            scan_din <= 1'b1;
        end else begin
            state    <= state_n;
            div_cnt  <= div_n;
            per_cnt  <= per_n;
            grant    <= grant_n;
            rr       <= rr_n;
            sreg     <= sreg_n;
            rdata    <= rdata_n;
            scan_clk <= clk_n;
            scan_din <= din_n;
        end
    end

    always_comb begin
        state_n  = state;
        div_n    = div_cnt;
        per_n    = per_cnt;
        grant_n  = grant;
        rr_n     = rr;
        sreg_n   = sreg;
        rdata_n  = rdata;
        cap      = {scan_dout, rdata};
        win      = 1'b0;
        last_per = 1'b0;
        clk_n    = 1'b0;
        din_n    = 1'b1;

        case (state)
            ST_IDLE: begin
                div_n = '0;
                per_n = '0;
                if (req != 2'b00) begin
                    // win = 1 selects requester 1; rr only matters on a tie
                    win     = (req == 2'b10) || ((req == 2'b11) && rr);
                    grant_n = win ? 2'b10 : 2'b01;
                    sreg_n  = win ? pattern1 : pattern0;
                    state_n = ST_RESET;
                end
            end
            ST_RESET, ST_SHIFT: begin
                last_per = (state == ST_RESET) ? (per_cnt == RST_LAST) : (per_cnt == SH_LAST);
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (last_per) begin
                        per_n   = '0;
                        state_n = (state == ST_RESET) ? ST_SHIFT : ST_DONE;
                    end else begin
                        per_n = per_cnt + 1'b1;
                    end
                end else begin
                    div_n = div_cnt + 1'b1;
                end
                // Capture on the first high cycle of scan_clk; bits enter at the MSB and walk down
                if ((state == ST_SHIFT) && (div_cnt == DIV_HALF)) begin
                    rdata_n = cap[CHAIN_LEN:1];
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                grant_n = 2'b00;
                rr_n    = grant[0];
            end
            default: state_n = ST_IDLE;
        endcase

        clk_n = ((state_n == ST_RESET) || (state_n == ST_SHIFT)) && (div_n >= DIV_HALF);

        // scan_din only moves at period start, so it is stable over the rising edge
        if (state_n == ST_SHIFT) begin
            din_n = scan_din;
            if (div_n == '0) begin
                din_n  = sreg[0];
                sreg_n = sreg >> 1;
            end
        end
    end

    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_DONE);
    assign scan_reset = (state == ST_RESET);

endmodule

// File: tb/tb_scan_chain_scheduler.sv
// tb/tb_scan_chain_scheduler.sv - directed self-checking bench for scan_chain_scheduler
module tb_scan_chain_scheduler;

    localparam int CL = 8;
    localparam int CD = 4;
    localparam int RC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req;
    logic [CL-1:0] pattern0;
    logic [CL-1:0] pattern1;
    logic [1:0]    grant;
    logic          busy;
    logic          done;
    logic [CL-1:0] rdata;
    logic          scan_clk;
    logic          scan_din;
    logic          scan_reset;
    logic          scan_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign scan_dout = scan_din;

    scan_chain_scheduler #(
        .CHAIN_LEN   (CL),
        .CLK_DIV     (CD),
        .RESET_CYCLES(RC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .pattern0  (pattern0),
        .pattern1  (pattern1),
        .grant     (grant),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .scan_clk  (scan_clk),
        .scan_din  (scan_din),
        .scan_reset(scan_reset),
        .scan_dout (scan_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_grant"},      32'(grant),      32'd0);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_scan_clk"},   32'(scan_clk),   32'd0);
        chk({tag, "_scan_din"},   32'(scan_din),   32'd1);
        chk({tag, "_scan_reset"}, 32'(scan_reset), 32'd0);
        chk({tag, "_rdata"},      32'(rdata),      32'd0);
    endtask

    // Call right after driving req at a negedge; the next negedge is cycle T+1.
    // Returns at the negedge of T+42, the single IDLE cycle after done.
    task automatic xfer(input string tag, input logic [1:0] g, input logic [CL-1:0] pat, input bit keep);
        int dones = 0;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (done) dones++;
            if (i <= 41) begin
                chk({tag, "_grant"}, 32'(grant), 32'(g));
                chk({tag, "_busy"},  32'(busy),  32'd1);
                chk({tag, "_done"},  32'(done),  32'(i == 41));
            end
            if (i <= 40) begin
                chk({tag, "_scan_reset"}, 32'(scan_reset), 32'(i <= RC * CD));
                chk({tag, "_scan_clk"},   32'(scan_clk),   32'(((i - 1) % CD) >= CD / 2));
                chk({tag, "_scan_din"},   32'(scan_din),
                    (i <= RC * CD) ? 32'd1 : 32'(pat[(i - 1 - RC * CD) / CD]));
            end
            if (i == 41) begin
                chk({tag, "_rdata"},         32'(rdata),      32'(pat));
                chk({tag, "_done_din"},      32'(scan_din),   32'd1);
                chk({tag, "_done_scan_clk"}, 32'(scan_clk),   32'd0);
                chk({tag, "_done_reset"},    32'(scan_reset), 32'd0);
            end
            if (i == 42) begin
                chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
                chk({tag, "_idle_busy"},  32'(busy),  32'd0);
                chk({tag, "_idle_done"},  32'(done),  32'd0);
            end
            if (!keep && i == 20) begin
                req      = 2'b00;
                pattern0 = ~pattern0;
                pattern1 = ~pattern1;
            end
        end
        chk({tag, "_done_count"}, 32'(dones), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        req      = 2'b00;
        pattern0 = '0;
        pattern1 = '0;
        repeat (3) @(negedge clk);
        reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);
        reset_vals("por_idle");

        // Single transfer from requester 0; req drops and pattern flips mid-SHIFT
        pattern0 = 8'b00011100;
        pattern1 = 8'hFF;
        req      = 2'b01;
        xfer("single", 2'b01, 8'b00011100, 1'b0);

        // Contention held from reset: rr restarts at requester 0, then alternates
        rst_n    = 1'b0;
        req      = 2'b11;
        pattern0 = 8'hC5;
        pattern1 = 8'h5A;
        repeat (3) @(negedge clk);
        reset_vals("cont_rst");
        rst_n = 1'b1;
        xfer("cont0", 2'b01, 8'hC5, 1'b1);
        xfer("cont1", 2'b10, 8'h5A, 1'b1);
        xfer("cont2", 2'b01, 8'hC5, 1'b1);
        req = 2'b00;

        // Priority memory: requester 1 alone, then tie goes to requester 0
        pattern0 = 8'h81;
        pattern1 = 8'h6E;
        req      = 2'b10;
        xfer("prio1", 2'b10, 8'h6E, 1'b0);
        pattern0 = 8'h37;
        pattern1 = 8'hE4;
        req      = 2'b11;
        xfer("prio0", 2'b01, 8'h37, 1'b1);
        req = 2'b00;

        // Abort in SHIFT period 3, then a full restart
        pattern0 = 8'hA5;
        req      = 2'b01;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            chk("abort_pre_done", 32'(done), 32'd0);
        end
        chk("abort_in_shift_reset", 32'(scan_reset), 32'd0);
        chk("abort_in_shift_busy",  32'(busy),       32'd1);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            reset_vals("abort");
        end
        rst_n = 1'b1;
        xfer("restart", 2'b01, 8'hA5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_chain_scheduler.md
# scan_chain_scheduler

Shares one scan-chain port of the test PCB between two requesters (host interface and local preset logic). The block arbitrates round-robin, latches the winner's configuration pattern, and sequences the chain: a reset phase, then a serial shift of the pattern on a divided scan clock. It captures the bits the chain shifts out and reports completion. It replaces ad-hoc, single-source scan sequencing and is the only driver of the scan_clk/scan_din/scan_reset pins.

## Interface
- CHAIN_LEN, 8, scan chain length in bits (≥1)
- CLK_DIV, 128, scan_clk period in clk cycles (even, ≥4)
- RESET_CYCLES, 10, scan_clk periods that scan_reset is held high (≥1)

- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- req  in  2  level request per requester, bit i = requester i
- pattern0  in  CHAIN_LEN  requester 0 configuration, sampled at grant
- pattern1  in  CHAIN_LEN  requester 1 configuration, sampled at grant
- grant  out  2  one-hot owner of current transaction, 0 when idle
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at end of transaction
- rdata  out  CHAIN_LEN  bits captured from scan_dout, valid from done until next grant
- scan_clk  out  1  divided scan clock, registered
- scan_din  out  1  serial data to chain
- scan_reset  out  1  chain reset, active high
- scan_dout  in  1  serial data from chain end

## Operation
- States: IDLE, RESET, SHIFT, DONE.
- Reset values (rst_n low at a posedge): state IDLE, grant 0, busy 0, done 0, rdata 0, scan_clk 0, scan_din 1, scan_reset 0, div_cnt 0, rr pointer 0 (requester 0 preferred).
- IDLE: div_cnt held 0, scan_clk 0, scan_din 1, scan_reset 0.
  - If any req bit is set, go to RESET and set grant. A single request wins directly.
  - If both are set, the requester indicated by rr wins.
  - Latch the winner's pattern into an internal shift register.
- RESET: scan_reset 1, scan_din 1. Lasts exactly RESET_CYCLES scan_clk periods, then SHIFT.
- SHIFT: scan_reset 0. Lasts exactly CHAIN_LEN periods.
  - In period k (0-based), scan_din = latched pattern[k] (LSB first) for the whole period.
  - At the rising scan_clk cycle of period k, scan_dout is sampled into rdata[k].
- DONE: one clk cycle. done 1, grant still held, scan_din 1, scan_clk 0. rr is set to point at the requester that did not win. Next state IDLE.
- req changes or deassertion after grant are ignored until IDLE. Pattern input changes after grant are ignored.
- A requester still holding req in IDLE is re-arbitrated, so with both requests held, grants alternate.

## Timing
- div_cnt runs 0..CLK_DIV-1 in RESET and SHIFT, restarting at 0 on every state entry.
- scan_clk = 1 exactly in cycles with div_cnt ∈ [CLK_DIV/2, CLK_DIV-1]. Each period therefore starts low, and the rising edge is mid-period.
- scan_din and scan_reset change only in cycles where div_cnt = 0 (scan_clk low); they are stable across each rising edge.
- Phase transitions occur at the posedge after the div_cnt = CLK_DIV-1 cycle of the final period.
- Latency:
  - req seen in IDLE at cycle T gives RESET with grant at T+1.
  - SHIFT starts at T+1+RESET_CYCLES·CLK_DIV.
  - DONE occurs at T+1+(RESET_CYCLES+CHAIN_LEN)·CLK_DIV.
  - IDLE at DONE+1; the earliest next grant is DONE+2.
- rst_n low during any state aborts immediately to reset values: no done, rdata cleared, scan_reset dropped.
- Counter widths: div_cnt $clog2(CLK_DIV); period counter wide enough for max(RESET_CYCLES, CHAIN_LEN). No wrap beyond the stated terminal counts.

## Test plan
- Reset: hold rst_n low 3 cycles mid-activity, then release -> grant 0, busy 0, done 0, scan_clk 0, scan_din 1, scan_reset 0, rdata 0.
- Single transfer, CLK_DIV=4, RESET_CYCLES=2, CHAIN_LEN=8:
  - Stimulus: req=01 with pattern0=8'b00011100, scan_dout looped to scan_din.
  - Required response: scan_reset high for 8 cycles; scan_din sequence 0,0,1,1,1,0,0,0; done at T+41; rdata=8'b00011100; grant=01 from T+1 through T+41.
- Contention: req=11 held from reset -> grants in order 01, 10, 01, with exactly one cycle of IDLE between each done and the next grant.
- Drop mid-transfer: deassert req and change pattern0 during SHIFT -> transfer completes with the originally latched bits; done pulses once.
- Abort: pull rst_n low in SHIFT period 3 -> all outputs at reset values next cycle, no done. A following req restarts with a full RESET phase.
- Priority memory: req1 alone served, then req=11 -> requester 0 granted first.
